// File: rtl/aes_chip_sequencer.sv
// aes_chip_sequencer
//   Runs one AES test transaction at a time against the external AES-128 chip.
//   The block fetches a key/text/expect triple from the pattern generator and
//   sends key then text, MSB byte first, on the 9-bit chip bus at the chip byte
//   rate. It then collects the 16-byte result, compares it with the expected
//   value and keeps the pass/fail statistics used by the report path.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   work, enc          run enable and mode (enc is latched at FETCH)
//   gen_valid/ready    generator handshake; ready is a one-cycle accept strobe
//   gen_key/text/expect  generator triple
//   aes_tx[8:0]        chip bus: [8] frame active, [7:0] byte
//   aes_rx[8:0]        chip return bus (async): [8] toggles once per byte
//   busy               state is not IDLE
//   total, correct     saturating transaction counters
//   error_chip/generator  result and expect of the last failing transaction
//   timeout            sticky receive-timeout flag
module aes_chip_sequencer #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned AES_TX_FREQ    = 50_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         work,
    input  logic         enc,
    input  logic         gen_valid,
    output logic         gen_ready,
    input  logic [127:0] gen_key,
    input  logic [127:0] gen_text,
    input  logic [127:0] gen_expect,
    output logic [8:0]   aes_tx,
    input  logic [8:0]   aes_rx,
    output logic         busy,
    output logic [31:0]  total,
    output logic [31:0]  correct,
    output logic [127:0] error_chip,
    output logic [127:0] error_generator,
    output logic         timeout
);
    localparam int unsigned DIV   = CLK_FREQ / AES_TX_FREQ;
    localparam int unsigned DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [31:0]      WAIT_LAST = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_SEND    = 3'd2;
    localparam logic [2:0] ST_RECV    = 3'd3;
    localparam logic [2:0] ST_COMPARE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [255:0]     sh_q, sh_d;
    logic [8:0]       aes_tx_q, aes_tx_d;
    logic [127:0]     expect_q, expect_d;
    logic             enc_q, enc_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [4:0]       byte_cnt_q, byte_cnt_d;
    logic [3:0]       rx_cnt_q, rx_cnt_d;
    logic [31:0]      wait_cnt_q, wait_cnt_d;
    logic [127:0]     result_q, result_d;
    logic             tmo_txn_q, tmo_txn_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      total_q, total_d;
    logic [31:0]      correct_q, correct_d;
    logic [127:0]     error_chip_q, error_chip_d;
    logic [127:0]     error_gen_q, error_gen_d;

    // Synchroniser and edge history run in every state so that no stale
    // toggle is seen when RECV is entered.
    logic [8:0] rx_sync1_q, rx_sync2_q;
    logic       rx_prev_q;
    logic       rx_edge;

    assign rx_edge = rx_sync2_q[8] ^ rx_prev_q;

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        aes_tx_d     = aes_tx_q;
        expect_d     = expect_q;
        enc_d        = enc_q;
        div_cnt_d    = div_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        result_d     = result_q;
        tmo_txn_d    = tmo_txn_q;
        timeout_d    = timeout_q;
        total_d      = total_q;
        correct_d    = correct_q;
        error_chip_d = error_chip_q;
        error_gen_d  = error_gen_q;

        case (state_q)
            ST_IDLE: begin
                if (work) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (gen_valid) begin
                    sh_d       = {gen_key, gen_text};
                    expect_d   = gen_expect;
                    enc_d      = enc;
                    aes_tx_d   = {1'b1, gen_key[127:120]};
                    div_cnt_d  = '0;
                    byte_cnt_d = '0;
                    rx_cnt_d   = '0;
                    wait_cnt_d = '0;
                    result_d   = '0;
                    tmo_txn_d  = 1'b0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (byte_cnt_q == 5'd31) begin
                        aes_tx_d = '0;
                        state_d  = ST_RECV;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                        sh_d       = {sh_q[247:0], 8'h00};
                        aes_tx_d   = {1'b1, sh_q[247:240]};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_RECV: begin
                if (rx_edge) begin
                    // Bytes are placed by position so a timeout leaves the
                    // missing low-order bytes at zero.
                    for (int unsigned i = 0; i < 16; i++) begin
                        if (rx_cnt_q == 4'(15 - i)) result_d[i*8 +: 8] = rx_sync2_q[7:0];
                    end
                    rx_cnt_d   = rx_cnt_q + 4'd1;
                    wait_cnt_d = '0;
                    if (rx_cnt_q == 4'd15) state_d = ST_COMPARE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    tmo_txn_d = 1'b1;
                    state_d   = ST_COMPARE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            ST_COMPARE: begin
                total_d = (total_q == '1) ? total_q : total_q + 32'd1;
                if (result_q == expect_q && !tmo_txn_q) begin
                    correct_d = (correct_q == '1) ? correct_q : correct_q + 32'd1;
                end else begin
                    error_chip_d = result_q;
                    error_gen_d  = expect_q;
                end
                state_d = work ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sh_q         <= '0;
            aes_tx_q     <= '0;
            expect_q     <= '0;
            enc_q        <= 1'b0;
            div_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            rx_cnt_q     <= '0;
            wait_cnt_q   <= '0;
            result_q     <= '0;
            tmo_txn_q    <= 1'b0;
            timeout_q    <= 1'b0;
            total_q      <= '0;
            correct_q    <= '0;
            error_chip_q <= '0;
            error_gen_q  <= '0;
            rx_sync1_q   <= '0;
            rx_sync2_q   <= '0;
            rx_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            aes_tx_q     <= aes_tx_d;
            expect_q     <= expect_d;
            enc_q        <= enc_d;
            div_cnt_q    <= div_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            result_q     <= result_d;
            tmo_txn_q    <= tmo_txn_d;
            timeout_q    <= timeout_d;
            total_q      <= total_d;
            correct_q    <= correct_d;
            error_chip_q <= error_chip_d;
            error_gen_q  <= error_gen_d;
            rx_sync1_q   <= aes_rx;
            rx_sync2_q   <= rx_sync1_q;
            rx_prev_q    <= rx_sync2_q[8];
        end
    end

    assign gen_ready       = (state_q == ST_FETCH) && gen_valid;
    assign busy            = (state_q != ST_IDLE);
    assign aes_tx          = aes_tx_q;
    assign total           = total_q;
    assign correct         = correct_q;
    assign error_chip      = error_chip_q;
    assign error_generator = error_gen_q;
    assign timeout         = timeout_q;
endmodule

// File: tb/tb_aes_chip_sequencer.sv
// Bench for aes_chip_sequencer with DIV=4 and TIMEOUT_CYCLES=100.
module tb_aes_chip_sequencer;
    localparam int unsigned TMO = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         work = 1'b0;
    logic         enc = 1'b0;
    logic         gen_valid = 1'b0;
    logic         gen_ready;
    logic [127:0] gen_key = '0;
    logic [127:0] gen_text = '0;
    logic [127:0] gen_expect = '0;
    logic [8:0]   aes_tx;
    logic [8:0]   aes_rx = '0;
    logic         busy;
    logic [31:0]  total, correct;
    logic [127:0] error_chip, error_generator;
    logic         timeout;

    aes_chip_sequencer #(
        .CLK_FREQ(200),
        .AES_TX_FREQ(50),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .work(work), .enc(enc),
        .gen_valid(gen_valid), .gen_ready(gen_ready),
        .gen_key(gen_key), .gen_text(gen_text), .gen_expect(gen_expect),
        .aes_tx(aes_tx), .aes_rx(aes_rx), .busy(busy),
        .total(total), .correct(correct),
        .error_chip(error_chip), .error_generator(error_generator),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] text;
        logic [127:0] expv;
        logic [127:0] chip;
        int           nbytes;
        bit           exp_pass;
    } vec_t;

    typedef struct {
        logic [31:0]  total;
        logic [31:0]  correct;
        logic [127:0] echip;
        logic [127:0] egen;
        logic         tmo;
    } exp_t;

    vec_t  vecs[4];
    exp_t  sb[$];
    int    checks = 0;
    int    failures = 0;

    logic [31:0]  m_total, m_correct;
    logic [127:0] m_echip, m_egen;
    logic         m_tmo;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    task automatic model_clear();
        m_total = '0; m_correct = '0; m_echip = '0; m_egen = '0; m_tmo = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_aes_tx"}, aes_tx, '0);
        chk({tag, "_gen_ready"}, gen_ready, '0);
        chk({tag, "_busy"}, busy, '0);
        chk({tag, "_total"}, total, '0);
        chk({tag, "_correct"}, correct, '0);
        chk({tag, "_error_chip"}, error_chip, '0);
        chk({tag, "_error_generator"}, error_generator, '0);
        chk({tag, "_timeout"}, timeout, '0);
    endtask

    // Drives one transaction, checks the serialised frame cycle by cycle,
    // plays the chip, and compares statistics against the scoreboard.
    // rst_at >= 0 asserts reset after that many returned bytes instead.
    task automatic run_txn(input vec_t v, input bit drop_work, input int rst_at);
        logic [255:0] frame;
        logic [127:0] mask, got;
        logic [8:0]   exp9;
        exp_t         e;
        int           n;
        frame = {v.key, v.text};

        @(negedge clk);
        gen_key = v.key; gen_text = v.text; gen_expect = v.expv;
        gen_valid = 1'b1;
        enc = 1'($urandom_range(0, 1));
        #1;
        n = 0;
        while (!gen_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("fetch_accept", gen_ready, 1'b1);

        if (rst_at < 0) begin
            mask = '1;
            mask = mask >> (8 * v.nbytes);
            got = v.chip & ~mask;
            m_total = sat_inc(m_total);
            if (v.exp_pass) m_correct = sat_inc(m_correct);
            else begin m_echip = got; m_egen = v.expv; end
            if (v.nbytes < 16) m_tmo = 1'b1;
            e.total = m_total; e.correct = m_correct;
            e.echip = m_echip; e.egen = m_egen; e.tmo = m_tmo;
            sb.push_back(e);
        end

        @(posedge clk);
        @(negedge clk);
        gen_valid = 1'b0;
        gen_key = '0; gen_text = '0; gen_expect = '0;
        enc = ~enc;
        chk("ready_one_cycle", gen_ready, 1'b0);
        for (int i = 0; i < 128; i++) begin
            exp9 = {1'b1, frame[255 - 8*(i/4) -: 8]};
            chk("send_byte", aes_tx, exp9);
            if (drop_work && i == 20) work = 1'b0;
            @(negedge clk);
        end
        chk("send_end_idle", aes_tx, 9'h000);

        for (int k = 0; k < v.nbytes; k++) begin
            if (rst_at == k) begin
                rst = 1'b1;
                #1;
                check_all_zero("rst_in_recv");
                @(negedge clk);
                rst = 1'b0;
                model_clear();
                return;
            end
            aes_rx = {~aes_rx[8], v.chip[127 - 8*k -: 8]};
            repeat (4) @(negedge clk);
        end

        if (v.nbytes < 16) repeat (TMO + 10) @(negedge clk);
        else repeat (10) @(negedge clk);

        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk("total", total, e.total);
            chk("correct", correct, e.correct);
            chk("error_chip", error_chip, e.echip);
            chk("error_generator", error_generator, e.egen);
            chk("timeout", timeout, e.tmo);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, 128'h00112233445566778899AABBCCDDEEFF,
                    128'h69C4E0D86A7B0430D8CDB78070B4C55A, 128'h69C4E0D86A7B0430D8CDB78070B4C55A, 16, 1'b1};
        vecs[1] = '{128'h000102030405060708090A0B0C0D0E0F, 128'h00112233445566778899AABBCCDDEEFF,
                    128'h69C4E0D86A7B0430D8CDB78070B4C55A, 128'h69C4E0D86A7B0430D8CDB78070B4C55B, 16, 1'b0};
        vecs[2] = '{128'h2B7E151628AED2A6ABF7158809CF4F3C, 128'h3243F6A8885A308D313198A2E0370734,
                    128'h3925841D02DC09FBDC118597196A0B32, 128'h3925841D02DC09FBDC118597196A0B32, 16, 1'b1};
        vecs[3] = '{128'h000102030405060708090A0B0C0D0E0F, 128'h00112233445566778899AABBCCDDEEFF,
                    128'h69C4E0D86A7B0430D8CDB78070B4C55A, 128'h69C4E0D86A7B0430D8CDB78070B4C55A, 10, 1'b0};

        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Table: pass, mismatch, second pass, timeout with 10 bytes.
        work = 1'b1;
        for (int t = 0; t < 4; t++) run_txn(vecs[t], 1'b0, -1);
        chk("timeout_low48_zero", error_chip[47:0], '0);
        chk("timeout_high80", error_chip[127:48], vecs[3].chip[127:48]);

        // work drops during SEND of the third transaction.
        work = 1'b0;
        do_reset();
        work = 1'b1;
        run_txn(vecs[0], 1'b0, -1);
        run_txn(vecs[1], 1'b0, -1);
        run_txn(vecs[2], 1'b1, -1);
        chk("idle_after_drop_busy", busy, 1'b0);
        repeat (20) @(negedge clk);
        chk("idle_total_stable", total, 32'd3);

        // Reset in the middle of RECV clears everything at once.
        work = 1'b1;
        run_txn(vecs[0], 1'b0, 5);
        work = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("after_rst");

        // Saturation of both counters.
        @(negedge clk);
        dut.total_q   = 32'hFFFF_FFFF;
        dut.correct_q = 32'hFFFF_FFFF;
        m_total   = 32'hFFFF_FFFF;
        m_correct = 32'hFFFF_FFFF;
        work = 1'b1;
        run_txn(vecs[0], 1'b0, -1);
        work = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_chip_sequencer.md
# aes_chip_sequencer

Sequences one AES test transaction at a time against the external AES-128 chip on the verification platform. It fetches a key/text/expected-result triple from the pattern generator and serialises key and text onto the 9-bit chip bus at the chip byte rate. It then collects the 16-byte result from the chip, compares it with the expected value, and maintains the pass/fail statistics consumed by the ASCII report path. It sits between the pattern generator and the chip pins, under the `work`/`enc` control coming from the UART command receiver.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `AES_TX_FREQ`, 50_000: byte rate on the chip bus in Hz; `DIV = CLK_FREQ/AES_TX_FREQ` cycles per byte (1000 by default; must be at least 4).
- `TIMEOUT_CYCLES`, 1_000_000: maximum number of cycles to wait for each returned byte.
- `clk` in 1: system clock. Everything is in this domain except `aes_rx`.
- `rst` in 1: asynchronous, active-high reset.
- `work` in 1: run enable. When high, the block loops over transactions.
- `enc` in 1: mode, 1 = encrypt, 0 = decrypt. Sampled at FETCH and held for the whole transaction.
- `gen_valid` in 1: the generator has a triple ready.
- `gen_ready` out 1: one-cycle accept strobe.
- `gen_key` in 128: cipher key.
- `gen_text` in 128: input block.
- `gen_expect` in 128: expected chip output.
- `aes_tx` out 9: chip bus. [8] is the frame-active flag; [7:0] is the byte.
- `aes_rx` in 9: chip return bus, asynchronous. [8] toggles once per new byte; [7:0] is the byte.
- `busy` out 1: high whenever the state is not IDLE.
- `total` out 32: completed transactions, saturating.
- `correct` out 32: matching transactions, saturating.
- `error_chip` out 128: chip result of the last failing transaction.
- `error_generator` out 128: expected value of the last failing transaction.
- `timeout` out 1: sticky flag, set by any receive timeout.

## Operation
- **Reset values:** state IDLE. All outputs are 0: `aes_tx=9'h000`, `gen_ready`, `busy`, `total`, `correct`, `error_chip`, `error_generator`, `timeout`.
- **IDLE:** if `work=1`, go to FETCH.
- **FETCH:** wait for `gen_valid`.
  - In the cycle `gen_valid=1`, assert `gen_ready` for exactly one cycle.
  - In that same cycle, latch key, text, expect and `enc`.
  - Then go to SEND.
- **SEND:** drive 32 bytes, each held for `DIV` cycles.
  - Order: key bytes [127:120] down to [7:0], then text bytes [127:120] down to [7:0].
  - `aes_tx[8]=1` throughout SEND.
  - After the last byte, `aes_tx` returns to 9'h000 and the state goes to RECV.
- **RECV:**
  - `aes_rx` passes through a 2-flop synchroniser.
  - An edge is detected when synchronised bit [8] differs from its previous sample.
  - On an edge, capture synchronised [7:0] into the result shift register, MSB byte first. Data is sampled on the same synchronised cycle as the edge.
  - After 16 bytes, go to COMPARE.
  - A wait counter restarts on every captured byte. If it reaches `TIMEOUT_CYCLES`, set `timeout` and go to COMPARE with the bytes not yet received left as 0.
- **COMPARE:** lasts one cycle.
  - `total` increments.
  - If result == expect and no timeout occurred in this transaction, `correct` increments.
  - Otherwise, load `error_chip` with the result and `error_generator` with the expect value.
  - Next state: FETCH if `work=1`, else IDLE.
- **Counters:** saturate at 32'hFFFF_FFFF; an increment at the maximum value leaves it unchanged. `correct` never exceeds `total`.
- **`work` falling mid-transaction:** the current transaction completes normally; stopping happens only at COMPARE.
- **`enc` changing mid-transaction:** ignored until the next FETCH.
- **Edges outside RECV:** ignored, but the synchroniser and edge history still track, so no stale edge is seen on entry to RECV.

## Timing
- FETCH accept: `gen_ready` is high in the same cycle as `gen_valid` when the state is FETCH. SEND byte 0 appears on `aes_tx` in the following cycle.
- SEND lasts exactly 32×`DIV` cycles. Each byte changes on a `DIV` boundary with no gap cycles.
- RX latency: a toggle on `aes_rx[8]` is captured 2 cycles later (synchroniser) plus 1 cycle (edge register).
- COMPARE to FETCH: 1 cycle. The minimum transaction length is 1 + 32×`DIV` + RX time + 1 cycles.
- Statistic outputs are registered and update in the cycle after COMPARE.
- `rst` asserted at any point: immediate return to the reset values, with no partial statistics update.

## Test plan
- **Single pass:** reset, `work=1`, generator provides key=000102…0F, text=00112233…FF, and the chip model echoes expect=69C4E0D8…C55A. Required: `total=1`, `correct=1`, error registers stay 0.
- **Mismatch:** chip model returns expect XOR 128'h1. Required: `total=1`, `correct=0`, `error_chip`=expect^1, `error_generator`=expect.
- **Timeout:** chip model returns only 10 bytes; use `TIMEOUT_CYCLES=100` in the bench. Required: `timeout=1`, `total=1`, `correct=0`, `error_chip` low 48 bits = 0.
- **Serialisation:** with `DIV=4`, check `aes_tx` shows 32 bytes, 4 cycles each, key MSB first, [8]=1, then 9'h000.
- **Mid-run `work` drop:** drop `work` during SEND of transaction 3. Required: transaction 3 completes, `total=3`, then IDLE with `busy=0`. Also assert `rst` during RECV of a later run: all outputs return to 0 immediately.
- **Saturation:** force `total`/`correct` to 32'hFFFF_FFFF via backdoor, run one passing transaction. Required: both remain at 32'hFFFF_FFFF.
